// File: rtl/booth_mult_r4_pkg.sv
// booth_pkg: FSM states, Booth digit control encodings and iteration-count helper
package booth_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {logic neg; logic two; logic zero;} booth_ctl_t;
  localparam booth_ctl_t BD_ZERO = 3'b001;
  localparam booth_ctl_t BD_P1   = 3'b000;
  localparam booth_ctl_t BD_P2   = 3'b010;
  localparam booth_ctl_t BD_M1   = 3'b100;
  localparam booth_ctl_t BD_M2   = 3'b110;
  function automatic int booth_niter(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_mult_r4_if.sv
// booth_mult_r4_if: request/result bundle; BOOTH_ACC_EN adds the acc request bit
interface booth_mult_r4_if #(parameter int WIDTH = 8);
  logic start, tc;
  logic [WIDTH-1:0] a, b;
  logic busy, valid;
  logic [2*WIDTH-1:0] z;
`ifdef BOOTH_ACC_EN
  logic acc;
  modport master(output start, tc, a, b, acc, input busy, valid, z);
  modport slave(input start, tc, a, b, acc, output busy, valid, z);
`else
  modport master(output start, tc, a, b, input busy, valid, z);
  modport slave(input start, tc, a, b, output busy, valid, z);
`endif
endinterface

// File: rtl/booth_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder, multiplier triplet to {neg, two, zero}
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0] i_trip,
  output booth_ctl_t o_ctl
);
  assign o_ctl = (i_trip == 3'b000 || i_trip == 3'b111) ? BD_ZERO :
                 (i_trip == 3'b011) ? BD_P2 :
                 (i_trip == 3'b100) ? BD_M2 :
                 i_trip[2] ? BD_M1 : BD_P1;
endmodule

// File: rtl/booth_mult_r4.sv
// booth_mult_r4: radix-4 Booth sequential multiplier; BOOTH_ACC_EN adds product accumulation
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  booth_mult_r4_if.slave s_if
);
  localparam int NITER = booth_niter(WIDTH);
  localparam int CW = $clog2(NITER);
  localparam int PW = 2 * WIDTH + 4;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_p, w_pn;
  logic r_q, r_valid, r_acc, w_last, w_acc;
  logic [WIDTH+1:0] r_a;
  logic [2*WIDTH-1:0] r_z;
  logic [WIDTH+3:0] w_mag, w_sum;
  booth_ctl_t w_ctl;
`ifdef BOOTH_ACC_EN
  assign w_acc = s_if.acc;
`else
  assign w_acc = 1'b0;
`endif
  booth_r4_enc u_enc (.i_trip({r_p[1:0], r_q}), .o_ctl(w_ctl));
  always_comb begin
    w_mag = w_ctl.zero ? '0 : w_ctl.two ? {r_a[WIDTH+1], r_a, 1'b0} : {{2{r_a[WIDTH+1]}}, r_a};
    w_sum = {{2{r_p[PW-1]}}, r_p[PW-1:WIDTH+2]} + (w_ctl.neg ? -w_mag : w_mag);
    w_pn  = {w_sum, r_p[WIDTH+1:2]};
  end
  assign w_last = (r_state == RUN) && (r_cnt == CW'(NITER - 1));
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && s_if.start) w_next = RUN;
    if (w_last) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // Upper field gets two guard bits during the add so a +/-2a digit never overflows before the shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= 1'b0;
      r_a     <= '0;
      r_acc   <= 1'b0;
      r_z     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (r_state == IDLE) begin
        if (s_if.start) begin
          r_a   <= {{2{s_if.tc & s_if.a[WIDTH-1]}}, s_if.a};
          r_p   <= {{(WIDTH+2){1'b0}}, {2{s_if.tc & s_if.b[WIDTH-1]}}, s_if.b};
          r_q   <= 1'b0;
          r_cnt <= '0;
          r_acc <= w_acc;
        end
      end else begin
        r_p   <= w_pn;
        r_q   <= r_p[1];
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_z <= r_acc ? r_z + w_pn[2*WIDTH-1:0] : w_pn[2*WIDTH-1:0];
      end
    end
  end
  assign s_if.busy  = (r_state == RUN);
  assign s_if.valid = r_valid;
  assign s_if.z     = r_z;
endmodule

// File: tb/tb_booth_mult_r4.sv
// tb_booth_mult_r4: directed and randomized checks of booth_mult_r4 at WIDTH=8 and WIDTH=16
module tb_booth_mult_r4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  booth_mult_r4_if #(8)  b8 ();
  booth_mult_r4_if #(16) b16 ();
  logic acc8 = 1'b0, acc16 = 1'b0;
`ifdef BOOTH_ACC_EN
  localparam bit HAS_ACC = 1'b1;
  assign b8.acc  = acc8;
  assign b16.acc = acc16;
`else
  localparam bit HAS_ACC = 1'b0;
`endif
  booth_mult_r4 #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .s_if(b8));
  booth_mult_r4 #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .s_if(b16));

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Exact product of the operands interpreted per tc, optionally added to the previous z
  function automatic logic [31:0] ref_z(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input bit tc, input bit ac, input logic [31:0] zp);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (tc && a[w-1]) av -= longint'(1) << w;
    if (tc && b[w-1]) bv -= longint'(1) << w;
    p = av * bv + (ac ? longint'(zp) : 64'sd0);
    return (w == 16) ? 32'(p) : {16'h0, 16'(p)};
  endfunction

  bit m8_busy, m8_valid, m16_busy, m16_valid;
  int m8_left, m16_left;
  logic [15:0] m8_z, m8_pend;
  logic [31:0] m16_z, m16_pend;

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m8_busy = 0; m8_valid = 0; m8_left = 0; m8_z = '0;
    end else begin
      m8_valid = 0;
      if (m8_busy) begin
        m8_left--;
        if (m8_left == 0) begin m8_busy = 0; m8_valid = 1; m8_z = m8_pend; end
      end else if (b8.start) begin
        m8_busy = 1; m8_left = 8 / 2 + 1;
        m8_pend = 16'(ref_z(8, {8'h0, b8.a}, {8'h0, b8.b}, b8.tc, acc8, {16'h0, m8_z}));
      end
    end

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m16_busy = 0; m16_valid = 0; m16_left = 0; m16_z = '0;
    end else begin
      m16_valid = 0;
      if (m16_busy) begin
        m16_left--;
        if (m16_left == 0) begin m16_busy = 0; m16_valid = 1; m16_z = m16_pend; end
      end else if (b16.start) begin
        m16_busy = 1; m16_left = 16 / 2 + 1;
        m16_pend = ref_z(16, b16.a, b16.b, b16.tc, acc16, m16_z);
      end
    end

  always @(negedge clk) begin
    chk("busy8", 32'(b8.busy), 32'(m8_busy));
    chk("valid8", 32'(b8.valid), 32'(m8_valid));
    chk("z8", 32'(b8.z), 32'(m8_z));
    chk("busy16", 32'(b16.busy), 32'(m16_busy));
    chk("valid16", 32'(b16.valid), 32'(m16_valid));
    chk("z16", b16.z, m16_z);
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit tc, input bit ac,
                      input logic [15:0] exp, input string n);
    int k;
    @(negedge clk);
    b8.a = a; b8.b = b; b8.tc = tc; acc8 = ac; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    k = 0;
    while (!b8.valid && k < 12) begin @(negedge clk); k++; end
    chk({n, "_lat"}, 32'(k), 32'd5);
    chk(n, 32'(b8.z), 32'(exp));
    chk({n, "_model"}, 32'(m8_z), 32'(exp));
  endtask

  int pulses;
  logic [15:0] zseen;

  initial begin
    b8.start = 0; b8.a = '0; b8.b = '0; b8.tc = 0;
    b16.start = 0; b16.a = '0; b16.b = '0; b16.tc = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(b8.busy), 32'd0);
    chk("rst_valid", 32'(b8.valid), 32'd0);
    chk("rst_z", 32'(b8.z), 32'd0);
    rst = 1'b1;
    run8(8'h80, 8'h80, 1, 0, 16'h4000, "m128sq");
    run8(8'd127, 8'hFF, 1, 0, 16'hFF81, "p127xm1");
    run8(8'hFF, 8'hFF, 0, 0, 16'hFE01, "u255sq");
    // start during RUN must be dropped
    @(negedge clk);
    b8.a = 8'd3; b8.b = 8'd5; b8.tc = 0; acc8 = 0; b8.start = 1;
    @(negedge clk); b8.start = 0;
    @(negedge clk); b8.a = 8'd7; b8.b = 8'd7; b8.start = 1;
    @(negedge clk); b8.start = 0;
    pulses = 0; zseen = '0;
    repeat (8) begin
      @(negedge clk);
      if (b8.valid) begin pulses++; zseen = b8.z; end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_z", 32'(zseen), 32'd15);
    // reset mid-operation
    @(negedge clk);
    b8.a = 8'd9; b8.b = 8'd9; b8.tc = 0; b8.start = 1;
    @(negedge clk); b8.start = 0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(b8.busy), 32'd0);
    chk("mrst_valid", 32'(b8.valid), 32'd0);
    chk("mrst_z", 32'(b8.z), 32'd0);
    @(negedge clk); rst = 1'b1;
    run8(8'd9, 8'd9, 0, 0, 16'd81, "after_rst");
`ifdef BOOTH_ACC_EN
    run8(8'd3, 8'd4, 0, 0, 16'd12, "acc_3x4");
    run8(8'd5, 8'd6, 0, 1, 16'd42, "acc_5x6");
    run8(8'hFF, 8'hFF, 0, 0, 16'hFE01, "acc_base");
    run8(8'hFF, 8'hFF, 0, 1, 16'hFC02, "acc_wrap");
`endif
    fork
      begin
        repeat (30000) begin
          @(negedge clk);
          b8.start = $urandom_range(0, 7) != 0;
          b8.a = 8'($urandom); b8.b = 8'($urandom);
          b8.tc = 1'($urandom_range(0, 1));
          acc8 = HAS_ACC ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        b8.start = 0;
      end
      begin
        repeat (30000) begin
          @(negedge clk);
          b16.start = $urandom_range(0, 7) != 0;
          b16.a = 16'($urandom); b16.b = 16'($urandom);
          b16.tc = 1'($urandom_range(0, 1));
          acc16 = HAS_ACC ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        b16.start = 0;
      end
    join
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
